// File: rtl/dcm_pkg.sv
// Shared constants, requester indices and arbiter state type for the DC-motor
// register file arbiter.
package dcm_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;
  localparam int STAT_W = 16;

  localparam logic [IDX_W-1:0] REQ_SPI = 3'd0;
  localparam logic [IDX_W-1:0] REQ_MC  = 3'd1;
  localparam logic [IDX_W-1:0] REQ_AUX = 3'd2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Next round-robin start point; requester 0 never takes part in the rotation.
  function automatic logic [IDX_W-1:0] rr_advance(input logic [IDX_W-1:0] idx,
                                                  input int n_req);
    if (int'(idx) >= n_req - 1) return IDX_W'(1);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/dcm_regfile_arbiter_if.sv
// Request/response bundle between the register-file requesters (master side)
// and the arbiter (slave side).
interface dcm_regfile_arbiter_if
  import dcm_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = dcm_pkg::ADDR_W,
  parameter int DATA_W = dcm_pkg::DATA_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dcm_regfile_ram.sv
// Single-port 2^ADDR_W x DATA_W register-file RAM, one-cycle registered read.
// Written so synthesis maps it onto a block RAM with a resettable output register.
module dcm_regfile_ram
  import dcm_pkg::*;
#(
  parameter int ADDR_W = dcm_pkg::ADDR_W,
  parameter int DATA_W = dcm_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset branch; a reset loop over every word would
  // stop the memory mapping onto block RAM. Only the output register resets.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dcm_regfile_arbiter.sv
// Register-file arbiter: requester 0 has fixed priority, the others rotate;
// supports locked multi-access sequences with starvation and lock-timeout guards.
// Optional per-requester grant counters are built when DCM_ARB_STATS_EN is defined.
module dcm_regfile_arbiter
  import dcm_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = dcm_pkg::ADDR_W,
  parameter int DATA_W   = dcm_pkg::DATA_W,
  parameter int MAX_WAIT = 15,
  parameter int LOCK_MAX = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  dcm_regfile_arbiter_if.slave      bus,
`ifdef DCM_ARB_STATS_EN
  input  logic                      stats_clear,
  output logic [N_REQ*STAT_W-1:0]   grant_count,
`endif
  output logic                      lock_timeout,
  output logic [IDX_W-1:0]          owner,
  output logic                      locked
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic               lock_timeout_q, lock_timeout_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic               rr_found;
  logic [IDX_W-1:0]   rr_pick;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_lock;
  logic               gnt_write;
  logic [N_REQ-1:0]   grant;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin : arbitrate
    rr_found = 1'b0;
    rr_pick  = REQ_MC;
    // Lowest pending RR index overall, then lowest at or after rr_ptr overrides it.
    for (int i = N_REQ - 1; i >= 1; i--) begin
      if (bus.req_valid[i]) begin
        rr_found = 1'b1;
        rr_pick  = IDX_W'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 1; i--) begin
      if (bus.req_valid[i] && (IDX_W'(i) >= rr_ptr_q)) begin
        rr_pick = IDX_W'(i);
      end
    end

    gnt_valid = 1'b0;
    gnt_idx   = REQ_SPI;
    if (state_q == ARB_LOCKED) begin
      gnt_idx = owner_q;
      for (int i = 0; i < N_REQ; i++) begin
        if (IDX_W'(i) == owner_q) gnt_valid = bus.req_valid[i];
      end
    end else if ((wait_cnt_q == WAIT_W'(MAX_WAIT)) && rr_found) begin
      gnt_valid = 1'b1;
      gnt_idx   = rr_pick;
    end else if (bus.req_valid[REQ_SPI]) begin
      gnt_valid = 1'b1;
      gnt_idx   = REQ_SPI;
    end else if (rr_found) begin
      gnt_valid = 1'b1;
      gnt_idx   = rr_pick;
    end

    grant     = '0;
    gnt_lock  = 1'b0;
    gnt_write = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = gnt_valid && (IDX_W'(i) == gnt_idx);
      if (grant[i]) begin
        gnt_lock  = bus.req_lock[i];
        gnt_write = bus.req_write[i];
        ram_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        ram_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin : next_state
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    wait_cnt_d     = wait_cnt_q;
    lock_cnt_d     = lock_cnt_q;
    lock_timeout_d = lock_timeout_q;
    rsp_valid_d    = grant & {N_REQ{~gnt_write}};

    unique case (state_q)
      ARB_IDLE: begin
        lock_cnt_d = '0;
        if (gnt_valid && (gnt_idx != REQ_SPI)) begin
          rr_ptr_d = rr_advance(gnt_idx, N_REQ);
        end
        if (gnt_valid && gnt_lock) begin
          state_d = ARB_LOCKED;
          owner_d = gnt_idx;
        end
      end
      ARB_LOCKED: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        // Timeout wins over the owner's lock bit; an access accepted now still completes.
        if (lock_cnt_q == LOCK_W'(LOCK_MAX - 1)) begin
          state_d        = ARB_IDLE;
          lock_timeout_d = 1'b1;
        end else if (gnt_valid && !gnt_lock) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (!rr_found || (gnt_valid && (gnt_idx != REQ_SPI))) begin
      wait_cnt_d = '0;
    end else if (gnt_valid && (wait_cnt_q != WAIT_W'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ARB_IDLE;
      owner_q        <= REQ_SPI;
      rr_ptr_q       <= REQ_MC;
      wait_cnt_q     <= '0;
      lock_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
      rsp_valid_q    <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      wait_cnt_q     <= wait_cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      lock_timeout_q <= lock_timeout_d;
      rsp_valid_q    <= rsp_valid_d;
    end
  end

  // An access granted during reset must not touch the RAM.
  dcm_regfile_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (gnt_valid && !reset),
    .we    (gnt_write),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

`ifdef DCM_ARB_STATS_EN
  logic [N_REQ*STAT_W-1:0] grant_count_q, grant_count_d;

  always_comb begin : stats_next
    grant_count_d = grant_count_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (stats_clear) begin
        grant_count_d[i*STAT_W +: STAT_W] = '0;
      end else if (grant[i] && (grant_count_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
        grant_count_d[i*STAT_W +: STAT_W] = grant_count_q[i*STAT_W +: STAT_W] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count_q <= '0;
    end else begin
      grant_count_q <= grant_count_d;
    end
  end

  assign grant_count = grant_count_q;
`endif

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = ram_rdata;
  assign lock_timeout  = lock_timeout_q;
  assign owner         = owner_q;
  assign locked        = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_dcm_regfile_arbiter.sv
// Directed self-checking bench for dcm_regfile_arbiter (N_REQ=3, MAX_WAIT=15,
// LOCK_MAX=16); inputs change on the falling edge, outputs are sampled there too.
module tb_dcm_regfile_arbiter;
  import dcm_pkg::*;

  localparam int N   = 3;
  localparam int SPI = int'(REQ_SPI);
  localparam int MC  = int'(REQ_MC);
  localparam int AUX = int'(REQ_AUX);

  logic       clk = 1'b0;
  logic       reset;
  logic       lock_timeout;
  logic       locked;
  logic [2:0] owner;
`ifdef DCM_ARB_STATS_EN
  logic                stats_clear;
  logic [N*STAT_W-1:0] grant_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dcm_regfile_arbiter_if #(.N_REQ(N)) bus ();

  dcm_regfile_arbiter #(
    .N_REQ    (N),
    .MAX_WAIT (15),
    .LOCK_MAX (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
`ifdef DCM_ARB_STATS_EN
    .stats_clear  (stats_clear),
    .grant_count  (grant_count),
`endif
    .lock_timeout (lock_timeout),
    .owner        (owner),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic w, input logic lk,
                       input logic [6:0] a, input logic [7:0] d);
    bus.req_valid[i]                     = 1'b1;
    bus.req_write[i]                     = w;
    bus.req_lock[i]                      = lk;
    bus.req_addr[i*ADDR_W +: ADDR_W]     = a;
    bus.req_wdata[i*DATA_W +: DATA_W]    = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  logic [7:0] burst_data [3];

  initial begin
    burst_data = '{8'h12, 8'h34, 8'h56};
    reset = 1'b1;
    clear_reqs();
`ifdef DCM_ARB_STATS_EN
    stats_clear = 1'b0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready",     32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rdata",     32'(bus.rsp_rdata), 0);
    check("rst_timeout",   32'(lock_timeout),  0);
    check("rst_locked",    32'(locked),        0);
    check("rst_owner",     32'(owner),         0);
`ifdef DCM_ARB_STATS_EN
    check("rst_grant_count", 32'(grant_count[31:0]), 0);
`endif
    reset = 1'b0;

    // Round-robin between 1 and 2 with requester 0 idle: 1,2,1,2,...
    @(negedge clk);
    drive(MC,  1'b1, 1'b0, 7'h70, 8'hA1);
    drive(AUX, 1'b1, 1'b0, 7'h71, 8'hA2);
    for (int c = 0; c < 6; c++) begin
      #1 check($sformatf("rr_alt[%0d]", c), 32'(bus.req_ready), (c % 2 == 0) ? 2 : 4);
      @(negedge clk);
    end
    clear_reqs();

    // Req0 writes 0x05=0x3C, req1 reads it back in the very next cycle
    @(negedge clk);
    drive(SPI, 1'b1, 1'b0, 7'h05, 8'h3C);
    #1 check("pre_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    clear_reqs();
    drive(MC, 1'b0, 1'b0, 7'h05, 8'h00);
    #1 check("rd1_ready", 32'(bus.req_ready), 2);
    @(negedge clk);
    check("rd1_rsp_valid", 32'(bus.rsp_valid), 2);
    check("rd1_rdata",     32'(bus.rsp_rdata), 'h3C);
    clear_reqs();
    @(negedge clk);
    check("rd1_rsp_pulse", 32'(bus.rsp_valid), 0);

    // Starvation guard: 15 grants to req0, then one to req1, repeating
    drive(SPI, 1'b0, 1'b0, 7'h05, 8'h00);
    drive(MC,  1'b0, 1'b0, 7'h05, 8'h00);
    for (int c = 0; c < 32; c++) begin
      #1 check($sformatf("starve[%0d]", c), 32'(bus.req_ready), (c % 16 == 15) ? 2 : 1);
      @(negedge clk);
    end
    clear_reqs();

    // Locked write burst by req1 while req0 waits
    @(negedge clk);
    drive(MC, 1'b1, 1'b1, 7'h01, 8'h12);
    #1 check("lk_b0_ready", 32'(bus.req_ready), 2);
    @(negedge clk);
    check("lk_locked", 32'(locked), 1);
    check("lk_owner",  32'(owner),  1);
    bus.req_valid[MC] = 1'b0;
    drive(SPI, 1'b0, 1'b0, 7'h01, 8'h00);
    #1 check("lk_owner_idle_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    drive(MC, 1'b1, 1'b1, 7'h02, 8'h34);
    #1 check("lk_b1_ready", 32'(bus.req_ready), 2);
    @(negedge clk);
    drive(MC, 1'b1, 1'b0, 7'h03, 8'h56);
    #1 check("lk_b2_ready", 32'(bus.req_ready), 2);
    @(negedge clk);
    bus.req_valid[MC] = 1'b0;
    #1 check("lk_released", 32'(locked), 0);
    check("lk_spi_ready", 32'(bus.req_ready), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("lk_rd_valid[%0d]", k), 32'(bus.rsp_valid), 1);
      check($sformatf("lk_rd_data[%0d]", k),  32'(bus.rsp_rdata), 32'(burst_data[k]));
      if (k < 2) drive(SPI, 1'b0, 1'b0, 7'(k + 2), 8'h00);
      else       clear_reqs();
    end

    // Lock timeout: req2 takes the lock with a read of 0x05 and goes quiet
    @(negedge clk);
    drive(AUX, 1'b0, 1'b1, 7'h05, 8'h00);
    #1 check("to_ready", 32'(bus.req_ready), 4);
    @(negedge clk);
    check("to_rsp_valid", 32'(bus.rsp_valid), 4);
    check("to_rdata",     32'(bus.rsp_rdata), 'h3C);
    check("to_locked",    32'(locked), 1);
    check("to_owner",     32'(owner),  2);
    bus.req_valid[AUX] = 1'b0;
    drive(SPI, 1'b0, 1'b0, 7'h05, 8'h00);
    for (int k = 0; k < 16; k++) begin
      #1 check($sformatf("to_hold_ready[%0d]", k), 32'(bus.req_ready), 0);
      check($sformatf("to_hold_flag[%0d]", k), 32'(lock_timeout), 0);
      @(negedge clk);
    end
    #1 check("to_forced_release", 32'(locked), 0);
    check("to_flag_set",   32'(lock_timeout), 1);
    check("to_spi_ready",  32'(bus.req_ready), 1);
    clear_reqs();
    repeat (3) @(negedge clk);
    check("to_flag_sticky", 32'(lock_timeout), 1);

    // Reset in the cycle a locked read is accepted
    drive(MC, 1'b1, 1'b1, 7'h20, 8'h77);
    @(negedge clk);
    check("rl_locked", 32'(locked), 1);
    drive(MC, 1'b0, 1'b1, 7'h20, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_reqs();
    check("rl_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rl_locked_clr", 32'(locked), 0);
    check("rl_timeout_clr", 32'(lock_timeout), 0);
    check("rl_owner_clr", 32'(owner), 0);
    check("rl_rdata_clr", 32'(bus.rsp_rdata), 0);
`ifdef DCM_ARB_STATS_EN
    check("rl_grant_count", 32'(grant_count[31:0]), 0);
`endif

    // A write accepted during reset leaves the RAM untouched
    @(negedge clk);
    drive(SPI, 1'b1, 1'b0, 7'h05, 8'hEE);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(SPI, 1'b0, 1'b0, 7'h05, 8'h00);
    @(negedge clk);
    clear_reqs();
    check("rw_rsp_valid", 32'(bus.rsp_valid), 1);
    check("rw_rdata",     32'(bus.rsp_rdata), 'h3C);
`ifdef DCM_ARB_STATS_EN
    check("st_count_spi", 32'(grant_count[15:0]), 1);
    drive(SPI, 1'b0, 1'b0, 7'h05, 8'h00);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    clear_reqs();
    check("st_clear_prio", 32'(grant_count[15:0]), 0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
